// File: rtl/lc3_pkg.sv
// lc3_pkg: LC-3 types and constants shared by the fetch unit and control decoder
package lc3_pkg;
  typedef enum logic [1:0] {S_ADDR, S_REQ, S_LOAD, S_VALID} fetch_state_e;
  localparam logic [15:0] LC3_RESET_PC = 16'h3000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_EXT = 4'b1011;
endpackage

// File: rtl/lc3_fetch_unit_if.sv
// lc3_fetch_unit_if: memory read port, decoder handshake and PC redirect bundle
interface lc3_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  inst_valid;
  logic                  dec_ready;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  modport master (
    output mem_req, mem_addr, instruction, inst_valid, inst_pc,
    input  mem_rdata, mem_ready, dec_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  mem_req, mem_addr, instruction, inst_valid, inst_pc,
    output mem_rdata, mem_ready, dec_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/lc3_pc_reg.sv
// lc3_pc_reg: program counter with async reset, priority load and wrapping increment
module lc3_pc_reg #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_pc_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] pc_o
);
  logic [WIDTH-1:0] pc_q, pc_d;
  always_comb pc_d = load_i ? load_pc_i : inc_i ? pc_q + WIDTH'(1) : pc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/lc3_fetch_unit.sv
// lc3_fetch_unit: LC-3 fetch front end owning PC/MAR/MDR/IR, with timeout retry and redirect
module lc3_fetch_unit
  import lc3_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(LC3_RESET_PC),
  parameter int                    MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  lc3_fetch_unit_if.master      bus,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  mar_le_o,
  output logic                  mdr_le_o,
  output logic                  pc_le_o,
  output logic                  ir_le_o,
  output logic                  fetch_err_o
);
  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d, inst_pc_q, inst_pc_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d, ir_q, ir_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mar_le, mdr_le, ir_le, pc_inc, err;
  logic [3:0]            le_q;
  logic                  err_q;
  lc3_pc_reg #(.WIDTH(ADDR_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load_i(bus.redirect_valid), .load_pc_i(bus.redirect_pc),
    .inc_i(pc_inc), .pc_o(pc_o)
  );
  // Redirect pre-empts every state, so MDR/IR/PC+1 updates never happen alongside it
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    ir_d      = ir_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    mar_le    = 1'b0;
    mdr_le    = 1'b0;
    ir_le     = 1'b0;
    pc_inc    = 1'b0;
    err       = 1'b0;
    if (bus.redirect_valid) state_d = S_ADDR;
    else case (state_q)
      S_ADDR: begin
        mar_d   = pc_o;
        mar_le  = 1'b1;
        cnt_d   = '0;
        state_d = S_REQ;
      end
      S_REQ:
        if (bus.mem_ready) begin
          mdr_d   = bus.mem_rdata;
          mdr_le  = 1'b1;
          state_d = S_LOAD;
        end else if (cnt_q == 8'(MAX_WAIT)) begin
          err     = 1'b1;
          state_d = S_ADDR;
        end else cnt_d = cnt_q + 8'd1;
      S_LOAD: begin
        ir_d      = mdr_q;
        inst_pc_d = mar_q;
        ir_le     = 1'b1;
        pc_inc    = 1'b1;
        state_d   = S_VALID;
      end
      S_VALID: state_d = bus.dec_ready ? S_ADDR : S_VALID;
      default: state_d = S_ADDR;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_ADDR;
      mar_q     <= '0;
      mdr_q     <= '0;
      ir_q      <= '0;
      inst_pc_q <= '0;
      cnt_q     <= '0;
      le_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      ir_q      <= ir_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      le_q      <= {mar_le, mdr_le, bus.redirect_valid | pc_inc, ir_le};
      err_q     <= err;
    end
  assign bus.mem_req     = state_q == S_REQ;
  assign bus.mem_addr    = mar_q;
  assign bus.instruction = ir_q;
  assign bus.inst_valid  = state_q == S_VALID;
  assign bus.inst_pc     = inst_pc_q;
  assign {mar_le_o, mdr_le_o, pc_le_o, ir_le_o} = le_q;
  assign fetch_err_o     = err_q;
endmodule

// File: tb/tb_lc3_fetch_unit.sv
// tb_lc3_fetch_unit: directed fetch scenarios checked against a queue of expected {addr, word}
module tb_lc3_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc;
  logic        mar_le, mdr_le, pc_le, ir_le, fetch_err;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  lc3_fetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
  lc3_fetch_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc_o(pc), .mar_le_o(mar_le), .mdr_le_o(mdr_le),
    .pc_le_o(pc_le), .ir_le_o(ir_le), .fetch_err_o(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic fetch(input logic [15:0] addr, input logic [15:0] data, input int waits, input bit push);
    int n = 0;
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 16'(bus.mem_req), 16'd1);
    chk("mem_addr", bus.mem_addr, addr);
    repeat (waits) begin
      @(negedge clk);
      chk("req_held", 16'(bus.mem_req), 16'd1);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = data;
    if (push) sb.push_back({addr, data});
    @(negedge clk);
    bus.mem_ready = 1'b0;
  endtask
  task automatic consume(input int hold);
    int n = 0;
    logic [31:0] e = 'x;
    while (!bus.inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 16'(bus.inst_valid), 16'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("instruction", bus.instruction, e[15:0]);
    chk("inst_pc", bus.inst_pc, e[31:16]);
    chk("pc_next", pc, e[31:16] + 16'd1);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 16'(bus.inst_valid), 16'd1);
      chk("hold_inst", bus.instruction, e[15:0]);
      chk("hold_noreq", 16'(bus.mem_req), 16'd0);
    end
    bus.dec_ready = 1'b1;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    chk("valid_drop", 16'(bus.inst_valid), 16'd0);
  endtask
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.dec_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 16'(bus.mem_req), 16'd0);
    chk("rst_valid", 16'(bus.inst_valid), 16'd0);
    chk("rst_inst", bus.instruction, 16'h0000);
    chk("rst_inst_pc", bus.inst_pc, 16'h0000);
    chk("rst_pc", pc, 16'h3000);
    chk("rst_strobes", 16'({mar_le, mdr_le, pc_le, ir_le, fetch_err}), 16'd0);
    rst = 1'b0;
    // zero-wait first fetch: request in cycle 1, valid in cycle 3
    @(negedge clk);
    chk("c1_req", 16'(bus.mem_req), 16'd1);
    chk("c1_addr", bus.mem_addr, 16'h3000);
    chk("c1_mar_le", 16'(mar_le), 16'd1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h1234;
    sb.push_back({16'h3000, 16'h1234});
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("c2_mdr_le", 16'(mdr_le), 16'd1);
    chk("c2_valid", 16'(bus.inst_valid), 16'd0);
    @(negedge clk);
    chk("c3_valid", 16'(bus.inst_valid), 16'd1);
    chk("c3_ir_le", 16'(ir_le), 16'd1);
    chk("c3_pc_le", 16'(pc_le), 16'd1);
    consume(10);
    fetch(16'h3001, 16'h5A5A, 2, 1'b1);
    consume(0);
    // timeout at MAX_WAIT=4 then retry of the same address
    @(negedge clk);
    chk("to_addr", bus.mem_addr, 16'h3002);
    chk("to_err0", 16'(fetch_err), 16'd0);
    repeat (4) begin
      @(negedge clk);
      chk("to_req", 16'(bus.mem_req), 16'd1);
      chk("to_err_early", 16'(fetch_err), 16'd0);
    end
    @(negedge clk);
    chk("to_req_drop", 16'(bus.mem_req), 16'd0);
    chk("to_err", 16'(fetch_err), 16'd1);
    @(negedge clk);
    chk("to_retry_req", 16'(bus.mem_req), 16'd1);
    chk("to_err_once", 16'(fetch_err), 16'd0);
    chk("to_retry_addr", bus.mem_addr, 16'h3002);
    fetch(16'h3002, 16'hC0DE, 0, 1'b1);
    consume(0);
    // redirect coincident with MEM_READY drops the data
    @(negedge clk);
    chk("rr_addr", bus.mem_addr, 16'h3003);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h4000;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("rr_req", 16'(bus.mem_req), 16'd0);
    chk("rr_valid", 16'(bus.inst_valid), 16'd0);
    chk("rr_pc", pc, 16'h4000);
    chk("rr_mdr_le", 16'(mdr_le), 16'd0);
    chk("rr_pc_le", 16'(pc_le), 16'd1);
    fetch(16'h4000, 16'h1111, 1, 1'b0);
    // redirect coincident with the decoder handshake takes REDIRECT_PC
    @(negedge clk);
    chk("rc_valid", 16'(bus.inst_valid), 16'd1);
    chk("rc_inst", bus.instruction, 16'h1111);
    chk("rc_inst_pc", bus.inst_pc, 16'h4000);
    bus.dec_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("rc_pc", pc, 16'hFFFF);
    chk("rc_valid_drop", 16'(bus.inst_valid), 16'd0);
    fetch(16'hFFFF, 16'h2222, 0, 1'b1);
    consume(0);
    fetch(16'h0000, 16'h3333, 0, 1'b1);
    consume(0);
    // redirect during S_LOAD suppresses the increment and the IR load
    fetch(16'h0001, 16'h4444, 0, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h5000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("rl_pc", pc, 16'h5000);
    chk("rl_valid", 16'(bus.inst_valid), 16'd0);
    chk("rl_ir_le", 16'(ir_le), 16'd0);
    chk("rl_inst", bus.instruction, 16'h3333);
    fetch(16'h5000, 16'h5555, 0, 1'b1);
    consume(0);
    // asynchronous reset in the middle of a request
    @(negedge clk);
    chk("ar_req_before", 16'(bus.mem_req), 16'd1);
    chk("ar_addr_before", bus.mem_addr, 16'h5001);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", 16'(bus.mem_req), 16'd0);
    chk("ar_addr", bus.mem_addr, 16'h0000);
    chk("ar_pc", pc, 16'h3000);
    chk("ar_inst", bus.instruction, 16'h0000);
    chk("ar_inst_pc", bus.inst_pc, 16'h0000);
    chk("ar_valid", 16'(bus.inst_valid), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(16'h3000, 16'h6666, 0, 1'b1);
    consume(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lc3_fetch_unit.md
Name: lc3_fetch_unit

Overview:
Instruction fetch front end for the LC-3 datapath. It owns PC, MAR, MDR and IR. It reads instruction words from memory over a request/ready interface and presents each word to the control decoder as INSTRUCTION with a valid/ready handshake. It accepts PC redirects from branch/jump resolution.

Parameters:
RESET_PC, 16'h3000, PC value loaded on reset.
ADDR_WIDTH, 16, memory address and PC width.
DATA_WIDTH, 16, instruction word width.
MAX_WAIT, 255, memory wait cycles tolerated before timeout/retry (8-bit counter).

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
MEM_REQ  output  1  read request, held until MEM_READY.
MEM_ADDR  output  ADDR_WIDTH  read address (= MAR).
MEM_RDATA  input  DATA_WIDTH  read data, valid when MEM_READY.
MEM_READY  input  1  read completes this cycle.
INSTRUCTION  output  DATA_WIDTH  IR contents to the decoder.
INST_VALID  output  1  INSTRUCTION is valid.
DEC_READY  input  1  decoder accepts INSTRUCTION this cycle.
INST_PC  output  ADDR_WIDTH  address INSTRUCTION was fetched from.
PC  output  ADDR_WIDTH  current PC (next fetch address).
REDIRECT_VALID  input  1  load PC from REDIRECT_PC, abort in-flight fetch.
REDIRECT_PC  input  ADDR_WIDTH  redirect target.
MAR_LE, MDR_LE, PC_LE, IR_LE  output  1 each  one-cycle latch-enable strobes (debug/observability).
FETCH_ERR  output  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset (async, active-high): state S_ADDR, PC=RESET_PC, MAR=0, MDR=0, IR=0, INST_PC=0, wait counter 0. All strobes, MEM_REQ, INST_VALID and FETCH_ERR are 0.
- S_ADDR (1 cycle): MAR<=PC, MAR_LE=1, counter<=0, then S_REQ.
- S_REQ: MEM_REQ=1, MEM_ADDR=MAR.
  - MEM_READY=1: MDR<=MEM_RDATA, MDR_LE=1, go to S_LOAD.
  - Otherwise counter increments. On counter==MAX_WAIT with no MEM_READY: FETCH_ERR pulses, go to S_ADDR and retry the same PC.
- S_LOAD (1 cycle): IR<=MDR, INST_PC<=MAR, PC<=PC+1 (modulo 2^ADDR_WIDTH, 16'hFFFF wraps to 0), IR_LE=PC_LE=1, then S_VALID.
- S_VALID: INST_VALID=1 and INSTRUCTION/INST_PC are stable. The transfer completes when INST_VALID&&DEC_READY, then go to S_ADDR. While DEC_READY=0, hold indefinitely.
- Latency: zero-wait memory gives INST_VALID 3 cycles after entering S_ADDR. Back-to-back throughput is one instruction per 4 cycles.
- Redirect (any state, highest priority): PC<=REDIRECT_PC, PC_LE=1, next state S_ADDR. In the cycle after, MEM_REQ=0 and INST_VALID=0.
  - Redirect coincident with MEM_READY: the data is dropped and MDR is not loaded.
  - Redirect coincident with INST_VALID&&DEC_READY: the instruction counts as consumed, and PC takes REDIRECT_PC, not PC.
  - Redirect during S_LOAD: the PC+1 increment is suppressed.
- FETCH_ERR is never asserted in the same cycle as a redirect; the redirect wins.
- MEM_READY outside S_REQ is ignored.
- INSTRUCTION always reflects IR. It is 0 after reset until the first S_LOAD.

Decomposition:
- Shared package lc3_pkg holds:
  - fetch state enum (S_ADDR, S_REQ, S_LOAD, S_VALID), 2-bit encoding;
  - LC3_RESET_PC constant (16'h3000);
  - opcode constants shared with the control decoder (OP_ADD 4'b0001, OP_AND 4'b0101, OP_NOT 4'b1001, OP_EXT 4'b1011).
- One natural sub-module: lc3_pc_reg. It is a PC register with async reset to RESET_PC, load (priority) and increment inputs.

Test Plan:
- Reset release, memory returns 16'h1234 with zero wait: MEM_ADDR=16'h3000 in cycle 1, INST_VALID=1 in cycle 3 with INSTRUCTION=16'h1234 and INST_PC=16'h3000, PC=16'h3001.
- DEC_READY held low 10 cycles: INST_VALID and INSTRUCTION stay stable with no new MEM_REQ. On DEC_READY=1, the next fetch is at 16'h3001.
- MEM_READY withheld past MAX_WAIT=4: FETCH_ERR pulses once after 4 waiting cycles, MEM_REQ drops for 1 cycle, and the retry uses the same address 16'h3000.
- REDIRECT_VALID with REDIRECT_PC=16'h4000 asserted in the same cycle as MEM_READY: the data is discarded, INST_VALID never rises for it, and the next MEM_ADDR is 16'h4000.
- PC=16'hFFFF fetch completes: INST_PC=16'hFFFF, PC=16'h0000, next MEM_ADDR=16'h0000.
- RESET asserted mid-S_REQ: all outputs go to reset values immediately, asynchronously. After release, the fetch restarts at 16'h3000.
